// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle CPU control path:
// sequencer state encoding, PC source codes and decoder constants.
package cpu_defs_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_e;

    localparam logic [1:0] PC_SRC_PC4 = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;

    localparam logic [2:0] ALUOP_BEQ = 3'b110;
    localparam logic [5:0] OPC_HALT  = 6'h3f;

    // True while the sequencer still executes instructions
    function automatic logic is_running(input state_e s);
        return !(s == S_HALT || s == S_ERROR);
    endfunction

endpackage

// File: rtl/seq_perf_counters.sv
// Saturating performance counter pair for the sequencer:
// active cycles and retired instructions.
module seq_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cyc_inc,
    input  logic             ret_inc,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_retired
);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    // Increment on request, stick at all-ones instead of wrapping
    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        if (cyc_inc && cyc_q != '1) begin
            cyc_d = cyc_q + 1'b1;
        end
        if (ret_inc && ret_q != '1) begin
            ret_d = ret_q + 1'b1;
        end
    end

    // Counter state, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cycle_count   = cyc_q;
    assign instr_retired = ret_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch handshake, IR, EXEC/MEM/WB stepping,
// memory timeout. Perf counters built only with SEQ_PERF_CNT_EN.
module cpu_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    input  logic [2:0]       dec_alu_op,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             dec_jump,
    input  logic             dec_noop,
    input  logic             alu_zero,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [31:0]    ir_q, ir_d;
    logic           req_q, req_d;
    logic [TO_W-1:0] to_q, to_d;
    logic           is_beq;
    logic           is_mem;

    assign is_beq = (dec_alu_op == ALUOP_BEQ);
    assign is_mem = dec_mem_read | dec_mem_write;

    // Requests come from a flop so reset drops them the next cycle
    assign imem_req = req_q && (state_q == S_FETCH);
    assign dmem_req = req_q && (state_q == S_MEM);
    assign ir       = ir_q;
    assign halted   = (state_q == S_HALT);
    assign error    = (state_q == S_ERROR);

    // Next-state, strobes and timeout bookkeeping
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        to_d     = to_q;
        pc_write = 1'b0;
        pc_src   = PC_SRC_PC4;
        rf_we    = 1'b0;
        dmem_we  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (req_q) begin
                    if (imem_ready) begin
                        ir_d     = imem_rdata;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (to_q == TO_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (dec_noop) begin
                    state_d = S_HALT;
                end else if (dec_jump) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JMP;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    pc_write = alu_zero;
                    pc_src   = PC_SRC_BR;
                    state_d  = S_FETCH;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_we = req_q & dec_mem_write;
                if (req_q) begin
                    if (dmem_ready) begin
                        state_d = dec_mem_write ? S_FETCH : S_WB;
                    end else if (to_q == TO_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_we   = dec_reg_write;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
        if (state_d != state_q &&
            (state_d == S_FETCH || state_d == S_MEM)) begin
            to_d = '0;
        end
        req_d = (state_d == S_FETCH) || (state_d == S_MEM);
    end

    // FSM, IR, request and timeout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            req_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            to_q    <= to_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic active;
    logic retire;

    assign active = is_running(state_q);
    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});

    seq_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .cyc_inc      (active),
        .ret_inc      (retire),
        .cycle_count  (cycle_count),
        .instr_retired(instr_retired)
    );
`else
    assign cycle_count   = '0;
    assign instr_retired = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed instruction stream,
// expected strobe events queued by stimulus, popped by a monitor.
module tb_cpu_sequencer;
    import cpu_defs_pkg::*;

    localparam int CNT_W = 32;
    localparam int TMO   = 4;

    localparam logic [31:0] I_ADD  = 32'h012A4020;
    localparam logic [31:0] I_LW   = 32'h8D280004;
    localparam logic [31:0] I_SW   = 32'hAD280008;
    localparam logic [31:0] I_BEQ  = 32'h11280003;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_HALT = 32'hFC000000;

    localparam int EV_PC   = 0;
    localparam int EV_RF   = 1;
    localparam int EV_DM   = 2;
    localparam int EV_HALT = 3;
    localparam int EV_ERR  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req;
    logic             imem_ready;
    logic [31:0]      imem_rdata;
    logic [31:0]      ir;
    logic [2:0]       dec_alu_op;
    logic             dec_mem_read;
    logic             dec_mem_write;
    logic             dec_reg_write;
    logic             dec_jump;
    logic             dec_noop;
    logic             alu_zero;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ready;
    logic             rf_we;
    logic             halted;
    logic             error;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_retired;

    cpu_sequencer #(
        .MEM_TIMEOUT(TMO),
        .TO_W       (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .dec_alu_op   (dec_alu_op),
        .dec_mem_read (dec_mem_read),
        .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write),
        .dec_jump     (dec_jump),
        .dec_noop     (dec_noop),
        .alu_zero     (alu_zero),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .rf_we        (rf_we),
        .halted       (halted),
        .error        (error),
        .cycle_count  (cycle_count),
        .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction decoder model driven from the IR
    always_comb begin
        dec_alu_op    = 3'b010;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_jump      = 1'b0;
        dec_noop      = 1'b0;
        case (ir[31:26])
            6'h00: dec_reg_write = 1'b1;
            6'h23: begin
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 3'b000;
            end
            6'h2b: begin
                dec_mem_write = 1'b1;
                dec_alu_op    = 3'b000;
            end
            6'h04: dec_alu_op = ALUOP_BEQ;
            6'h02: dec_jump = 1'b1;
            OPC_HALT: dec_noop = 1'b1;
            default: ;
        endcase
    end

    typedef struct {
        int kind;
        int data;
        int at;
    } ev_t;

    ev_t evq[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  exp_req_cyc = 0;
    int  p_rel = 0;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int data, input int at);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.at   = at;
        evq.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int data);
        ev_t e;
        n_cmp++;
        if (evq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: kind %0d data %0d cycle %0d",
                     kind, data, cyc);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || e.data != data || e.at != cyc) begin
                n_bad++;
                $display("FAIL event: got k%0d d%0d @%0d expected k%0d d%0d @%0d",
                         kind, data, cyc, e.kind, e.data, e.at);
            end
        end
    endtask

    // Monitor: every strobe or status edge pops one expected event
    logic halted_prev = 1'b0;
    logic error_prev  = 1'b0;
    always @(negedge clk) begin
        if (pc_write) pop_cmp(EV_PC, int'(pc_src));
        if (rf_we) pop_cmp(EV_RF, 1);
        if (dmem_req && dmem_ready) pop_cmp(EV_DM, int'(dmem_we));
        if (halted && !halted_prev) pop_cmp(EV_HALT, 1);
        if (error && !error_prev) pop_cmp(EV_ERR, 1);
        halted_prev = halted;
        error_prev  = error;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        step();
        step();
        rst   = 1'b0;
        p_rel = cyc;
        check("rst_imem_req", imem_req, 0);
        check("rst_ir", ir, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_cycles", cycle_count, 0);
        check("rst_retired", instr_retired, 0);
        exp_req_cyc = cyc + 1;
    endtask

    task automatic wait_imem_req();
        int t = 0;
        while (!imem_req && t < 20) begin
            step();
            t++;
        end
        check("fetch_req_seen", imem_req, 1);
    endtask

    // One instruction: iw imem waits, dw dmem waits (dw<0: never ready)
    task automatic run(input logic [31:0] instr, input int iw,
                       input int dw, input logic zero);
        int a;
        int t;
        logic [5:0] op;
        logic mem;
        op  = instr[31:26];
        mem = (op == 6'h23) || (op == 6'h2b);
        wait_imem_req();
        check("fetch_req_cycle", cyc, exp_req_cyc);
        for (int i = 0; i < iw; i++) begin
            check("imem_req_hold", imem_req, 1);
            step();
        end
        check("imem_req_at_ready", imem_req, 1);
        a = cyc;
        push(EV_PC, 0, a);
        case (op)
            6'h00: begin
                push(EV_RF, 1, a + 3);
                exp_req_cyc = a + 4;
            end
            6'h23: begin
                if (dw < 0) push(EV_ERR, 1, a + 3 + TMO);
                else begin
                    push(EV_DM, 0, a + 3 + dw);
                    push(EV_RF, 1, a + 4 + dw);
                    exp_req_cyc = a + 5 + dw;
                end
            end
            6'h2b: begin
                push(EV_DM, 1, a + 3 + dw);
                exp_req_cyc = a + 4 + dw;
            end
            6'h04: begin
                if (zero) push(EV_PC, 1, a + 2);
                exp_req_cyc = a + 3;
            end
            6'h02: begin
                push(EV_PC, 2, a + 1);
                exp_req_cyc = a + 2;
            end
            default: push(EV_HALT, 1, a + 2);
        endcase
        imem_ready = 1'b1;
        imem_rdata = instr;
        alu_zero   = zero;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("ir_loaded", ir, instr);
        if (mem) begin
            t = 0;
            while (!dmem_req && t < 10) begin
                step();
                t++;
            end
            check("dmem_req_cycle", cyc, a + 3);
            if (dw < 0) begin
                for (int i = 0; i < TMO; i++) begin
                    check("dmem_req_hold_to", dmem_req, 1);
                    step();
                end
                check("to_error", error, 1);
                check("to_dmem_drop", dmem_req, 0);
                for (int i = 0; i < 3; i++) begin
                    step();
                    check("err_no_req", imem_req | dmem_req, 0);
                end
                check("err_sticky", error, 1);
            end else begin
                for (int i = 0; i < dw; i++) begin
                    check("dmem_req_hold", dmem_req, 1);
                    check("dmem_we_hold", dmem_we, op == 6'h2b);
                    step();
                end
                dmem_ready = 1'b1;
                step();
                dmem_ready = 1'b0;
            end
        end else if (op == OPC_HALT) begin
            step();
            check("halted", halted, 1);
            for (int i = 0; i < 3; i++) begin
                step();
                check("halt_no_req", imem_req, 0);
            end
        end
    endtask

    initial begin
        int r;
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        alu_zero   = 1'b0;
        do_reset();

        run(I_ADD, 0, 0, 1'b0);
        run(I_LW, 2, 3, 1'b0);
        run(I_BEQ, 0, 0, 1'b1);
        run(I_BEQ, 1, 0, 1'b0);
        run(I_SW, 0, 1, 1'b0);
        run(I_J, 0, 0, 1'b0);
        run(I_HALT, 0, 0, 1'b0);

        do_reset();
        run(I_LW, 0, -1, 1'b0);

        do_reset();
        wait_imem_req();
        r = cyc;
        push(EV_ERR, 1, r + TMO);
        for (int i = 0; i < TMO; i++) begin
            check("fetch_to_hold", imem_req, 1);
            step();
        end
        check("fetch_to_error", error, 1);
        check("fetch_to_drop", imem_req, 0);

        do_reset();
        run(I_ADD, 0, 0, 1'b0);
        run(I_ADD, 0, 0, 1'b0);
        run(I_ADD, 1, 0, 1'b0);
        wait_imem_req();
        step();
`ifdef SEQ_PERF_CNT_EN
        check("retired_3", instr_retired, 3);
        check("cycles", cycle_count, cyc - p_rel);
`else
        check("retired_off", instr_retired, 0);
        check("cycles_off", cycle_count, 0);
`endif
        rst = 1'b1;
        step();
        check("rst_mid_req_drop", imem_req, 0);
        check("rst_mid_ir", ir, 0);
        check("rst_mid_retired", instr_retired, 0);
        rst        = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = I_ADD;
        step();
        imem_ready = 1'b0;
        check("late_ready_ignored", ir, 0);
        step();
        step();
        check("queue_drained", evq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
